control_unit: RTL and testbench

Hardwired Moore control sequencer for the Phase 2 datapath. It drives every strobe the `Datapath` module consumes: register-file selects, bus-source enables, register load enables, memory read/write and the 5-bit ALU `CONTROL` code. It fetches, decodes `IR[31:27]` and steps through one fixed T-state sequence per instruction. It sits directly upstream of `Datapath` and replaces hand-sequenced per-instruction stimulus.

---
 rtl/riscie_pkg.sv | 84 ++++++++
 rtl/control_decode.sv | 115 +++++++++++
 rtl/control_unit.sv | 109 ++++++++++
 tb/tb_control_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscie_pkg.sv
// Shared encodings for the Phase 2 control sequencer: opcodes, ALU codes, states, IR fields
// and the strobe bundle passed from the decoder to the top level.
package riscie_pkg;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpJr   = 5'b10011;
    localparam logic [4:0] OpJal  = 5'b10100;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [4:0] AluAdd = 5'b00000;
    localparam logic [4:0] AluSub = 5'b00001;
    localparam logic [4:0] AluAnd = 5'b00010;
    localparam logic [4:0] AluOr  = 5'b00011;

    localparam logic [3:0] StRst    = 4'b0000;
    localparam logic [3:0] StT0     = 4'b0001;
    localparam logic [3:0] StT1     = 4'b0010;
    localparam logic [3:0] StT2     = 4'b0011;
    localparam logic [3:0] StT3     = 4'b0100;
    localparam logic [3:0] StT4     = 4'b0101;
    localparam logic [3:0] StT5     = 4'b0110;
    localparam logic [3:0] StT6     = 4'b0111;
    localparam logic [3:0] StT7     = 4'b1000;
    localparam logic [3:0] StHalted = 4'b1001;

    localparam int unsigned IrOpHi = 31;
    localparam int unsigned IrOpLo = 27;
    localparam int unsigned IrRaHi = 26;
    localparam int unsigned IrRaLo = 23;
    localparam int unsigned IrRbHi = 22;
    localparam int unsigned IrRbLo = 19;
    localparam int unsigned IrRcHi = 18;
    localparam int unsigned IrRcLo = 15;

    typedef struct packed {
        logic       run;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic       pc_out;
        logic       mdr_out;
        logic       zlo_out;
        logic       c_out;
        logic       r_out;
        logic       pc_in;
        logic       mdr_in;
        logic       mar_in;
        logic       ir_in;
        logic       y_in;
        logic       zlo_in;
        logic       r_in;
        logic       g_ra;
        logic       g_rb;
        logic       g_rc;
        logic [4:0] control;
    } ctrl_t;

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpOr:    return AluOr;
            default: return AluAdd;
        endcase
    endfunction

    // Last T-state of each instruction; unknown opcodes behave as NOP.
    function automatic logic [3:0] last_state(input logic [4:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpAddi: return StT5;
            OpLd, OpSt:                        return StT7;
            OpJal:                             return StT6;
            default:                           return StT3;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational state x opcode -> datapath strobe decode.
module control_decode
    import riscie_pkg::*;
(
    input  logic [3:0] state,
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state >= StT0) && (state <= StT7);
        unique case (state)
            StT0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
            end
            StT1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            StT2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            StT3: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpLd, OpSt: begin
                        ctrl.g_rb  = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    OpJr: begin
                        ctrl.g_ra  = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    OpJal: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr: begin
                        ctrl.g_rc    = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlo_in  = 1'b1;
                        ctrl.control = alu_code(opcode);
                    end
                    OpAddi, OpLd, OpSt, OpJal: begin
                        ctrl.c_out   = 1'b1;
                        ctrl.zlo_in  = 1'b1;
                        ctrl.control = AluAdd;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpAddi: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.g_ra    = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    OpLd, OpSt: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.mar_in  = 1'b1;
                    end
                    OpJal: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.g_rb    = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                case (opcode)
                    OpLd: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    OpSt: begin
                        ctrl.g_ra   = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    OpJal: begin
                        ctrl.g_ra  = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                case (opcode)
                    OpLd: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.g_ra    = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    OpSt:    ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: state register, opcode latch and next-state logic for the
// Phase 2 datapath; strobes come from control_decode.
module control_unit
    import riscie_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  CONTROL,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        C_Out,
    output logic        R_Out,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        MAR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        R_In,
    output logic        G_RA,
    output logic        G_RB,
    output logic        G_RC
);

    localparam logic [1:0] HoldLast = 2'(RESET_PC_HOLD);

    logic [3:0] state_q, state_d;
    logic [1:0] hold_q, hold_d;
    logic [4:0] op_q;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign unused_ir = ^IR[IrRaHi:0];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            StRst: begin
                if (hold_q == HoldLast) begin
                    state_d = StT0;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end
            StHalted: ;
            StT0, StT1, StT2: state_d = state_q + 4'd1;
            StT3, StT4, StT5, StT6, StT7: begin
                if (state_q == last_state(op_q)) begin
                    state_d = (Stop || op_q == OpHalt) ? StHalted : StT0;
                end else begin
                    state_d = state_q + 4'd1;
                end
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= StRst;
            hold_q  <= 2'd0;
            op_q    <= OpNop;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (state_q == StT2) begin
                op_q <= IR[IrOpHi:IrOpLo];
            end
        end
    end

    control_decode u_decode (
        .state  (state_q),
        .opcode (op_q),
        .ctrl   (ctrl)
    );

    assign Run     = ctrl.run;
    assign CONTROL = ctrl.control;
    assign IncPC   = ctrl.inc_pc;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign PC_Out  = ctrl.pc_out;
    assign MDR_Out = ctrl.mdr_out;
    assign ZLO_Out = ctrl.zlo_out;
    assign C_Out   = ctrl.c_out;
    assign R_Out   = ctrl.r_out;
    assign PC_In   = ctrl.pc_in;
    assign MDR_In  = ctrl.mdr_in;
    assign MAR_In  = ctrl.mar_in;
    assign IR_In   = ctrl.ir_in;
    assign Y_In    = ctrl.y_in;
    assign ZLO_In  = ctrl.zlo_in;
    assign R_In    = ctrl.r_in;
    assign G_RA    = ctrl.g_ra;
    assign G_RB    = ctrl.g_rb;
    assign G_RC    = ctrl.g_rc;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, mid-instruction reset and
// randomized instruction streams against a per-instruction micro-step model.
module tb_control_unit;

    localparam int unsigned Hold = 2;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = 32'h0;
    logic        Run, IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, G_RA, G_RB, G_RC;
    logic [4:0]  CONTROL;

    int unsigned checks = 0;
    int unsigned errors = 0;

    control_unit #(.RESET_PC_HOLD(Hold)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .Run(Run), .CONTROL(CONTROL),
        .IncPC(IncPC), .Read(Read), .Write(Write), .PC_Out(PC_Out), .MDR_Out(MDR_Out),
        .ZLO_Out(ZLO_Out), .C_Out(C_Out), .R_Out(R_Out), .PC_In(PC_In), .MDR_In(MDR_In),
        .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In), .R_In(R_In),
        .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC)
    );

    always #5 Clock = ~Clock;

    // Observed outputs packed into one word; bit positions match the masks below.
    logic [23:0] dut_vec;
    assign dut_vec = {Run, G_RC, G_RB, G_RA, R_In, ZLO_In, Y_In, IR_In, MAR_In, MDR_In, PC_In,
                      R_Out, C_Out, ZLO_Out, MDR_Out, PC_Out, Write, Read, IncPC, CONTROL};

    localparam logic [23:0] MIncPc  = 24'd1 << 5;
    localparam logic [23:0] MRead   = 24'd1 << 6;
    localparam logic [23:0] MWrite  = 24'd1 << 7;
    localparam logic [23:0] MPcOut  = 24'd1 << 8;
    localparam logic [23:0] MMdrOut = 24'd1 << 9;
    localparam logic [23:0] MZloOut = 24'd1 << 10;
    localparam logic [23:0] MCOut   = 24'd1 << 11;
    localparam logic [23:0] MROut   = 24'd1 << 12;
    localparam logic [23:0] MPcIn   = 24'd1 << 13;
    localparam logic [23:0] MMdrIn  = 24'd1 << 14;
    localparam logic [23:0] MMarIn  = 24'd1 << 15;
    localparam logic [23:0] MIrIn   = 24'd1 << 16;
    localparam logic [23:0] MYIn    = 24'd1 << 17;
    localparam logic [23:0] MZloIn  = 24'd1 << 18;
    localparam logic [23:0] MRIn    = 24'd1 << 19;
    localparam logic [23:0] MGRa    = 24'd1 << 20;
    localparam logic [23:0] MGRb    = 24'd1 << 21;
    localparam logic [23:0] MGRc    = 24'd1 << 22;
    localparam logic [23:0] MRun    = 24'd1 << 23;
    localparam logic [23:0] T0Sig   = MPcOut | MMarIn | MIncPc;
    localparam logic [23:0] T0Word  = T0Sig | MRun;

    logic [23:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        stop;
        int unsigned cycles;
        logic        halts;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Micro-step list of one instruction, T0 onwards, written straight from the opcode table.
    task automatic build_exp(input logic [4:0] op);
        logic [23:0] rb_to_y, imm_add;
        rb_to_y = MGRb | MROut | MYIn;
        imm_add = MCOut | MZloIn;
        exp_q = {};
        exp_q.push_back(T0Sig);
        exp_q.push_back(MRead | MMdrIn);
        exp_q.push_back(MMdrOut | MIrIn);
        if (op >= 5'd3 && op <= 5'd6) begin
            exp_q.push_back(rb_to_y);
            exp_q.push_back(MGRc | MROut | MZloIn | {19'd0, op - 5'd3});
            exp_q.push_back(MZloOut | MGRa | MRIn);
        end else if (op == 5'd12) begin
            exp_q.push_back(rb_to_y);
            exp_q.push_back(imm_add);
            exp_q.push_back(MZloOut | MGRa | MRIn);
        end else if (op == 5'd0 || op == 5'd2) begin
            exp_q.push_back(rb_to_y);
            exp_q.push_back(imm_add);
            exp_q.push_back(MZloOut | MMarIn);
            if (op == 5'd0) begin
                exp_q.push_back(MRead | MMdrIn);
                exp_q.push_back(MMdrOut | MGRa | MRIn);
            end else begin
                exp_q.push_back(MGRa | MROut | MMdrIn);
                exp_q.push_back(MWrite);
            end
        end else if (op == 5'd19) begin
            exp_q.push_back(MGRa | MROut | MPcIn);
        end else if (op == 5'd20) begin
            exp_q.push_back(MPcOut | MYIn);
            exp_q.push_back(imm_add);
            exp_q.push_back(MZloOut | MGRb | MRIn);
            exp_q.push_back(MGRa | MROut | MPcIn);
        end else begin
            exp_q.push_back(24'd0);
        end
        foreach (exp_q[k]) exp_q[k] = exp_q[k] | MRun;
    endtask

    // Clear may drop anywhere in a cycle; T0 must appear Hold+1 edges after release.
    task automatic do_reset(input string name);
        Clear = 1'b0;
        Stop  = 1'b0;
        #1;
        check({name, " async clear"}, dut_vec, 24'd0);
        @(negedge Clock);
        Clear = 1'b1;
        for (int e = 1; e <= int'(Hold) + 1; e++) begin
            @(posedge Clock);
            #1;
            if (e <= int'(Hold)) check($sformatf("%s hold e%0d", name, e), dut_vec, 24'd0);
            else check({name, " first T0"}, dut_vec, T0Word);
        end
    endtask

    // Starts sampled in T0; returns cycles seen until the next T0 or a halt (bounded at 20).
    task automatic run_instr(input string name, input logic [31:0] ir, input logic stop,
                             output int unsigned cycles, output logic halted);
        int unsigned len;
        int unsigned i;
        build_exp(ir[31:27]);
        len = exp_q.size();
        i = 0;
        while (i < 20) begin
            if (i > 0 && ((dut_vec & T0Sig) == T0Sig || !dut_vec[23])) break;
            if (i < len) check($sformatf("%s c%0d", name, i), dut_vec, exp_q[i]);
            IR   = (i == 2) ? ir : $urandom();
            Stop = (i + 1 == len) ? stop : 1'($urandom_range(0, 1));
            @(posedge Clock);
            #1;
            i++;
        end
        Stop   = 1'b0;
        cycles = i;
        halted = !dut_vec[23];
    endtask

    task automatic finish_instr(input string name, input int unsigned cycles,
                                input int unsigned exp_cycles, input logic halted,
                                input logic exp_halt);
        check({name, " cycles"}, 24'(cycles), 24'(exp_cycles));
        check({name, " halted"}, {23'd0, halted}, {23'd0, exp_halt});
        if (exp_halt) begin
            for (int k = 0; k < 20; k++) begin
                IR   = $urandom();
                Stop = 1'($urandom_range(0, 1));
                check($sformatf("%s sticky %0d", name, k), dut_vec, 24'd0);
                @(posedge Clock);
                #1;
            end
            do_reset({name, " recover"});
        end else begin
            check({name, " next T0"}, dut_vec, T0Word);
        end
    endtask

    initial begin
        int unsigned cyc;
        logic        hlt;
        logic [4:0]  known[11];
        logic [4:0]  op;
        logic [31:0] ir;
        logic        stp;

        vecs[0]  = '{"JAL",     32'hA0F80001, 1'b0, 7, 1'b0};
        vecs[1]  = '{"ADD",     32'h191A0000, 1'b0, 6, 1'b0};
        vecs[2]  = '{"LD",      32'h00900055, 1'b0, 8, 1'b0};
        vecs[3]  = '{"JR",      32'h9A800000, 1'b0, 4, 1'b0};
        vecs[4]  = '{"ST",      32'h10900010, 1'b0, 8, 1'b0};
        vecs[5]  = '{"SUB",     32'h21A20000, 1'b0, 6, 1'b0};
        vecs[6]  = '{"AND",     32'h29A20000, 1'b0, 6, 1'b0};
        vecs[7]  = '{"OR",      32'h31A20000, 1'b0, 6, 1'b0};
        vecs[8]  = '{"ADDI",    32'h60900007, 1'b0, 6, 1'b0};
        vecs[9]  = '{"NOP",     32'hD0000000, 1'b0, 4, 1'b0};
        vecs[10] = '{"UNDEF",   32'hF8000000, 1'b0, 4, 1'b0};
        vecs[11] = '{"ADDSTOP", 32'h191A0000, 1'b1, 6, 1'b1};
        vecs[12] = '{"HALT",    32'hD8000000, 1'b0, 4, 1'b1};
        vecs[13] = '{"JRSTOP",  32'h9A800000, 1'b1, 4, 1'b1};
        known = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd19, 5'd20, 5'd26, 5'd27};

        #2;
        do_reset("reset");

        foreach (vecs[v]) begin
            run_instr(vecs[v].name, vecs[v].ir, vecs[v].stop, cyc, hlt);
            finish_instr(vecs[v].name, cyc, vecs[v].cycles, hlt, vecs[v].halts);
        end

        // Clear during LD T5, then a normal fetch afterwards.
        build_exp(5'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("midrst c%0d", i), dut_vec, exp_q[i]);
            IR   = (i == 2) ? 32'h00900055 : $urandom();
            Stop = 1'($urandom_range(0, 1));
            @(posedge Clock);
            #1;
        end
        check("midrst T5", dut_vec, exp_q[5]);
        #2;
        do_reset("midrst");
        run_instr("post-rst ADD", 32'h191A0000, 1'b0, cyc, hlt);
        finish_instr("post-rst ADD", cyc, 6, hlt, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                              : known[$urandom_range(0, 10)];
            ir  = {op, 27'($urandom())};
            stp = ($urandom_range(0, 9) == 0);
            run_instr($sformatf("rnd%0d op%0d", n, op), ir, stp, cyc, hlt);
            finish_instr($sformatf("rnd%0d op%0d", n, op), cyc, exp_q.size(), hlt,
                         stp || op == 5'd27);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
